// File: rtl/hash_stream_out.sv
// Egress stage for the hash generator: buffers 128-bit hashes in a FIFO and
// emits each one MSW-first as a packet of OUT_W-bit beats over valid/ready.
//
// state | meaning
// IDLE  | serializer empty, waiting for a buffered hash
// SEND  | presenting beats of the hash held in the shift register
module hash_stream_out #(
   parameter int DEPTH = 8,
   parameter int OUT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   input  logic [127:0]           i_hash,
   output logic                   o_valid,
   output logic [OUT_W-1:0]       o_data,
   output logic                   o_last,
   input  logic                   i_ready,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_full,
   output logic [15:0]            o_drop_cnt
);

   localparam int BEATS = 128 / OUT_W;
   localparam int AW    = $clog2(DEPTH);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t         state_q, state_d;
   logic [127:0]   shift_q, shift_d;
   logic [BW-1:0]  beat_q, beat_d;
   logic [127:0]   mem [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AW:0]    level_d;
   logic           wr_en, pop, handshake, at_last, fifo_nempty;

   // Fullness uses the registered level only, so a same-cycle pop never rescues a write.
   assign fifo_nempty = (o_level != '0);
   assign wr_en       = i_valid && !o_full;
   assign handshake   = o_valid && i_ready;
   assign at_last     = (beat_q == LAST_BEAT);

   assign o_valid = (state_q == SEND);
   assign o_data  = shift_q[127 -: OUT_W];
   assign o_last  = o_valid && at_last;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      beat_d  = beat_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (fifo_nempty) begin
               pop     = 1'b1;
               shift_d = mem[rd_ptr_q];
               beat_d  = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (handshake) begin
               if (!at_last) begin
                  shift_d = shift_q << OUT_W;
                  beat_d  = beat_q + 1'b1;
               end else if (fifo_nempty) begin
                  // reload straight from the FIFO so packets stream without a bubble
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr_q];
                  beat_d  = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   always_comb begin
      level_d = o_level;
      if (wr_en && !pop)
         level_d = o_level + 1'b1;
      else if (!wr_en && pop)
         level_d = o_level - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         beat_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         o_level    <= '0;
         o_full     <= 1'b0;
         o_drop_cnt <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         beat_q  <= beat_d;
         o_level <= level_d;
         o_full  <= (level_d == FULL_LVL);
         if (wr_en)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         if (i_valid && o_full && (o_drop_cnt != 16'hFFFF))
            o_drop_cnt <= o_drop_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_q] <= i_hash;
   end

endmodule

// File: tb/tb_hash_stream_out.sv
// Scoreboard bench for hash_stream_out: stimulus queues accepted hashes, an
// independent negedge monitor checks every beat against the queued hash.
module tb_hash_stream_out;

   localparam int DEPTH = 8;
   localparam int OUT_W = 32;
   localparam int BEATS = 128 / OUT_W;
   localparam logic [127:0] H1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   i_valid = 1'b0;
   logic [127:0]           i_hash = '0;
   logic                   i_ready = 1'b0;
   logic                   o_valid, o_last, o_full;
   logic [OUT_W-1:0]       o_data;
   logic [$clog2(DEPTH):0] o_level;
   logic [15:0]            o_drop_cnt;

   int checks = 0;
   int fails = 0;
   logic [127:0] exp_q[$];
   int beats_seen = 0;
   int pkts_seen = 0;
   bit pat[8] = '{0, 0, 1, 0, 1, 1, 0, 1};

   always #5 clk = ~clk;

   hash_stream_out #(.DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_hash(i_hash),
      .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready),
      .o_level(o_level), .o_full(o_full), .o_drop_cnt(o_drop_cnt)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Word b of a hash, counting from the most significant end.
   function automatic logic [OUT_W-1:0] word_of(input logic [127:0] h, input int b);
      return OUT_W'(h >> (128 - (b + 1) * OUT_W));
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic drain(input string name);
      bit done = 0;
      for (int n = 0; n < 2000 && !done; n++) begin
         if (exp_q.size() == 0 && !o_valid && o_level == 0) done = 1;
         else tick();
      end
      chk(name, done, 1);
   endtask

   // Monitor: one beat per negedge, compared against the head of the scoreboard.
   initial begin
      int mon_beat = 0;
      logic stall_prev = 0;
      logic [OUT_W-1:0] prev_data = '0;
      logic prev_last = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_q.delete();
            mon_beat = 0;
            stall_prev = 0;
         end else begin
            if (stall_prev) begin
               chk("hold_valid", o_valid, 1);
               chk("hold_data", o_data, prev_data);
               chk("hold_last", o_last, prev_last);
            end
            if (o_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", o_data, 'x);
               end else begin
                  chk("beat_data", o_data, word_of(exp_q[0], mon_beat));
                  chk("beat_last", o_last, (mon_beat == BEATS - 1));
                  if (i_ready) begin
                     beats_seen++;
                     if (mon_beat == BEATS - 1) begin
                        void'(exp_q.pop_front());
                        mon_beat = 0;
                        pkts_seen++;
                     end else begin
                        mon_beat++;
                     end
                  end
               end
            end
            stall_prev = o_valid && !i_ready;
            prev_data  = o_data;
            prev_last  = o_last;
         end
      end
   end

   initial begin
      int b0, p0, gaps, high, pushed;
      logic [127:0] h;

      rst = 1'b0;
      tick();
      tick();
      chk("rst_valid", o_valid, 0);
      chk("rst_last", o_last, 0);
      chk("rst_data", o_data, 0);
      chk("rst_level", o_level, 0);
      chk("rst_full", o_full, 0);
      chk("rst_drop", o_drop_cnt, 0);
      rst = 1'b1;
      tick();

      // single packet
      i_ready = 1; i_valid = 1; i_hash = H1; exp_q.push_back(H1);
      tick();
      i_valid = 0;
      chk("t1_level_c1", o_level, 1);
      chk("t1_valid_c1", o_valid, 0);
      tick();
      chk("t1_first_word", o_data, 32'h00112233);
      for (int c = 2; c <= 5; c++) begin
         chk("t1_valid", o_valid, 1);
         chk("t1_last", o_last, (c == 5));
         chk("t1_data", o_data, word_of(H1, c - 2));
         tick();
      end
      chk("t1_valid_c6", o_valid, 0);
      tick();

      // backpressure
      b0 = beats_seen; p0 = pkts_seen;
      i_ready = 0; i_valid = 1; i_hash = H1; exp_q.push_back(H1);
      tick();
      i_valid = 0;
      tick();
      for (int k = 0; k < 8; k++) begin
         i_ready = pat[k];
         tick();
      end
      i_ready = 0;
      chk("t2_handshakes", beats_seen - b0, 4);
      chk("t2_packets", pkts_seen - p0, 1);
      chk("t2_valid_after", o_valid, 0);

      // overflow
      b0 = beats_seen; p0 = pkts_seen;
      for (int i = 1; i <= 12; i++) begin
         i_valid = 1; i_hash = 128'(i);
         if (i <= DEPTH + 1) exp_q.push_back(128'(i));
         tick();
      end
      i_valid = 0;
      chk("t3_level", o_level, 8);
      chk("t3_full", o_full, 1);
      chk("t3_drop", o_drop_cnt, 3);
      i_ready = 1;
      drain("t3_drain");
      chk("t3_packets", pkts_seen - p0, 9);
      chk("t3_beats", beats_seen - b0, 36);
      chk("t3_level_end", o_level, 0);
      chk("t3_full_end", o_full, 0);

      // back-to-back
      do_reset();
      i_ready = 1; gaps = 0; high = 0;
      for (int c = 0; c < 46; c++) begin
         if (c % 4 == 0 && c < 40) begin
            h = rnd128(); i_valid = 1; i_hash = h; exp_q.push_back(h);
         end else begin
            i_valid = 0;
         end
         if (c >= 2 && c <= 41 && !o_valid) gaps++;
         if (o_valid) high++;
         tick();
      end
      i_valid = 0;
      chk("t4_gaps", gaps, 0);
      chk("t4_valid_cycles", high, 40);
      chk("t4_drop", o_drop_cnt, 0);
      drain("t4_drain");

      // saturation
      i_ready = 0;
      for (int i = 0; i < 65545; i++) begin
         h = rnd128(); i_valid = 1; i_hash = h;
         if (i < DEPTH + 1) exp_q.push_back(h);
         tick();
      end
      i_valid = 0;
      chk("t5_drop_sat", o_drop_cnt, 16'hFFFF);
      chk("t5_full", o_full, 1);
      for (int i = 0; i < 5; i++) begin
         i_valid = 1; i_hash = rnd128();
         tick();
      end
      i_valid = 0;
      chk("t5_drop_hold", o_drop_cnt, 16'hFFFF);
      i_ready = 1;
      drain("t5_drain");
      chk("t5_drop_after_drain", o_drop_cnt, 16'hFFFF);

      // reset mid-packet
      for (int i = 0; i < 4; i++) begin
         h = rnd128(); i_valid = 1; i_hash = h; exp_q.push_back(h);
         tick();
      end
      i_valid = 0;
      chk("t6_valid_beat2", o_valid, 1);
      chk("t6_level_pre", o_level, 3);
      rst = 0;
      tick();
      rst = 1;
      chk("t6_valid", o_valid, 0);
      chk("t6_level", o_level, 0);
      chk("t6_drop", o_drop_cnt, 0);
      high = 0;
      for (int c = 0; c < 10; c++) begin
         if (o_valid) high++;
         tick();
      end
      chk("t6_silent", high, 0);
      p0 = pkts_seen;
      h = rnd128(); i_valid = 1; i_hash = h; exp_q.push_back(h);
      tick();
      i_valid = 0;
      drain("t6_drain");
      chk("t6_packets", pkts_seen - p0, 1);

      // randomized traffic kept below capacity so nothing may be dropped
      p0 = pkts_seen; pushed = 0;
      for (int c = 0; c < 3000; c++) begin
         i_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0 && (pushed - (pkts_seen - p0)) < DEPTH) begin
            h = rnd128(); i_valid = 1; i_hash = h; exp_q.push_back(h); pushed++;
         end else begin
            i_valid = 0;
         end
         tick();
      end
      i_valid = 0; i_ready = 1;
      drain("rand_drain");
      chk("rand_packets", pkts_seen - p0, pushed);
      chk("rand_drop", o_drop_cnt, 0);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/hash_stream_out.md
# hash_stream_out

Egress stage directly downstream of the validator pipeline's hash generator. It captures each 128-bit hash on a single-cycle valid strobe. The upstream path has no backpressure, so hashes are buffered in a FIFO. Each buffered hash is emitted as a packet of narrower words over a valid/ready stream with a last-beat flag. Hashes arriving while the FIFO is full are dropped and counted.

## Interface

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, ≥ 2.
- OUT_W, 32, output word width; one of 8, 16, 32, 64, 128. BEATS = 128/OUT_W.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low; 0 resets the block on the next clk edge.
- i_valid  input  1  one-cycle strobe; i_hash is valid this cycle.
- i_hash  input  128  hash from the hash generator.
- o_valid  output  1  output beat valid.
- o_data  output  OUT_W  output beat data.
- o_last  output  1  high on the final beat of a packet.
- i_ready  input  1  downstream accepts the beat when o_valid && i_ready.
- o_level  output  $clog2(DEPTH)+1  FIFO occupancy; excludes the hash held in the serializer.
- o_full  output  1  o_level == DEPTH.
- o_drop_cnt  output  16  saturating count of dropped hashes.

## Operation

- Reset (rst=0 at an edge) clears the following:
  - o_valid, o_last, o_data, o_level, o_full, o_drop_cnt are all 0.
  - FIFO pointers are zeroed and contents are discarded.
  - The serializer returns to IDLE with its beat counter at 0.
- FIFO write:
  - When i_valid=1 and the registered o_full=0, i_hash is written.
  - When i_valid=1 and o_full=1, the hash is dropped and o_drop_cnt increments, saturating at 0xFFFF.
  - A pop in the same cycle does not rescue a write: fullness is judged on the registered count only.
- Occupancy: a simultaneous write and pop leaves o_level unchanged.
- Serializer FSM, 128-bit shift register plus beat counter:
  - IDLE: if o_level ≠ 0, pop the FIFO head into the shift register, set beat=0, go to SEND. o_valid=0 throughout IDLE.
  - SEND:
    - o_valid=1.
    - o_data = shift[127:128-OUT_W], so the most significant word goes first.
    - o_last = (beat == BEATS-1).
  - On a handshake with beat < BEATS-1: shift left by OUT_W and increment beat.
  - On a handshake on the last beat:
    - If o_level ≠ 0, load the next head, set beat=0, and stay in SEND. There is no bubble between packets.
    - Otherwise go to IDLE.
- Backpressure: while o_valid=1 and i_ready=0, o_data and o_last hold stable. o_valid is never withdrawn before its handshake.
- Total capacity is DEPTH+1 hashes: DEPTH in the FIFO plus one in the serializer.
- With OUT_W=128 (BEATS=1), every beat has o_last=1.
- Output order equals acceptance order. No reordering, no duplication.

## Timing

- Hash strobed in cycle N with the FIFO empty and the FSM in IDLE:
  - written at the end of N;
  - o_level=1 in N+1;
  - popped at the end of N+1;
  - first beat has o_valid=1 in N+2.
- The minimum i_valid-to-o_valid latency is 2 cycles.
- With i_ready held at 1, a packet takes BEATS consecutive cycles. Consecutive buffered packets stream with o_valid continuously high.
- o_level, o_full and o_drop_cnt are registered. They reflect events from the previous edge.
- Reset mid-packet: the current packet is abandoned with no further beats, and o_valid=0 from the first cycle after the reset edge.
- Sustained throughput without drops requires a mean input rate of at most 1 hash per BEATS cycles.

## Test plan

1. **Single packet.** DEPTH=8, OUT_W=32, i_ready=1. Strobe i_hash=0x00112233_44556677_8899AABB_CCDDEEFF at cycle 0.
   - Required: beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on cycles 2–5.
   - o_last=1 only on cycle 5; o_valid=0 on cycle 6.
2. **Backpressure.** Same hash; i_ready pattern 0,0,1,0,1,1,0,1 starting cycle 2.
   - Required: o_data and o_last hold while i_ready=0.
   - Exactly 4 handshakes, in order; o_last on the 4th.
3. **Overflow.** i_ready=0; 12 hashes strobed on cycles 0–11 with values 1..12.
   - Required after the burst: o_level=8, o_full=1, o_drop_cnt=3.
   - Then raise i_ready: exactly 9 packets (hashes 1–9) in order, 36 beats; o_level returns to 0 and o_full to 0.
4. **Back-to-back.** i_ready=1; a hash strobed every 4 cycles for 10 hashes.
   - Required: o_valid stays high continuously from the first beat to the 40th.
   - o_drop_cnt=0.
5. **Saturation.** i_ready=0; 65,545 hashes strobed.
   - Required: o_drop_cnt=0xFFFF and it stays there.
6. **Reset mid-packet.** Assert rst=0 for one cycle during beat 2 of a packet, with 3 hashes in the FIFO.
   - Required in the next cycle: o_valid=0, o_level=0, o_drop_cnt=0.
   - No beats emitted until a new hash arrives.
